// File: rtl/sync_tree_arb_ctl_if.sv
// rtl/sync_tree_arb_ctl_if.sv - child/parent four-phase handshake bundle for sync_tree_arb_ctl
// The lock vector exists only when SYNC_TREE_ARB_LOCK_EN is defined.
interface sync_tree_arb_ctl_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         treq;
  logic         tack;
  logic         busy;
`ifdef SYNC_TREE_ARB_LOCK_EN
  logic [N-1:0] lock;

  modport master (output req, tack, lock, input gnt, treq, busy);
  modport slave  (input req, tack, lock, output gnt, treq, busy);
`else
  modport master (output req, tack, input gnt, treq, busy);
  modport slave  (input req, tack, output gnt, treq, busy);
`endif
endinterface

// File: rtl/sync_tree_arb_ctl.sv
// rtl/sync_tree_arb_ctl.sv - clocked N-way round-robin tree arbiter cell (parent first, then child)
// Optional LOCKED state for back-to-back ownership is built when SYNC_TREE_ARB_LOCK_EN is defined.
module sync_tree_arb_ctl #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic              clk,
  input  logic              rst,
  sync_tree_arb_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TREQ    = 3'd1;
  localparam logic [2:0] S_GRANT   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  gnt_r;
  logic          treq_r;

  logic [PW-1:0] ptr_eff;
  logic [PW-1:0] pick;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  probe;
  int            idx;
  logic          req_w;

  // Scan from the lowest-priority end so the nearest set bit after ptr wins last.
  always_comb begin
    ptr_eff = (int'(ptr) >= N) ? PW'(N - 1) : ptr;
    pick    = '0;
    pick_oh = '0;
    probe   = '0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx   = (int'(ptr_eff) + k) % N;
      probe = N'(1) << idx;
      if (|(bus.req & probe)) begin
        pick    = PW'(idx);
        pick_oh = probe;
      end
    end
  end

  assign req_w    = |(bus.req & win_oh);
  assign bus.gnt  = gnt_r;
  assign bus.treq = treq_r;
  assign bus.busy = (state != S_IDLE);

`ifdef SYNC_TREE_ARB_LOCK_EN
  logic lock_w;
  assign lock_w = |(bus.lock & win_oh);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= PW'(N - 1);
      win_idx <= '0;
      win_oh  <= '0;
      gnt_r   <= '0;
      treq_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A parent still holding tack from an interrupted handshake must drop it first.
          if (!bus.tack && (|bus.req)) begin
            win_idx <= pick;
            win_oh  <= pick_oh;
            treq_r  <= 1'b1;
            state   <= S_TREQ;
          end
        end
        S_TREQ: begin
          if (bus.tack) begin
            if (req_w) begin
              gnt_r <= win_oh;
              ptr   <= win_idx;
              state <= S_GRANT;
            end else begin
              treq_r <= 1'b0;
              state  <= S_RELEASE;
            end
          end
        end
        S_GRANT: begin
          if (!req_w) begin
            gnt_r <= '0;
`ifdef SYNC_TREE_ARB_LOCK_EN
            if (lock_w) begin
              state <= S_LOCKED;
            end else begin
              treq_r <= 1'b0;
              state  <= S_RELEASE;
            end
`else
            treq_r <= 1'b0;
            state  <= S_RELEASE;
`endif
          end
        end
`ifdef SYNC_TREE_ARB_LOCK_EN
        S_LOCKED: begin
          // Parent stays owned; only the locking child may come back.
          if (req_w && lock_w) begin
            gnt_r <= win_oh;
            state <= S_GRANT;
          end else if (!lock_w) begin
            treq_r <= 1'b0;
            state  <= S_RELEASE;
          end
        end
`endif
        S_RELEASE: begin
          if (!bus.tack) begin
            state <= S_IDLE;
          end
        end
        default: begin
          gnt_r  <= '0;
          treq_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
